// File: rtl/bist_sequencer_pkg.sv
// Shared definitions for the BIST sequencer slice.
//   bist_state_e : sequencer FSM states (3-bit encoding kept from the original defines)
//   BIST_NCLOCK_DEFAULT : default number of running cycles per round
//   width_of()   : counter width able to hold 0..maxval, never below 1 bit
package bist_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_FINISH = 3'd3,
    ST_DONE   = 3'd4
  } bist_state_e;

  localparam int unsigned BIST_NCLOCK_DEFAULT = 650;

  function automatic int unsigned width_of(input int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/bist_sequencer_toggle_gen.sv
// Divided toggle stimulus for the circuit under test.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   en      : high for every cycle the sequencer will be in RUN next
//   clr     : high when the sequencer enters INIT (restarts the divider)
//   toggle  : registered stimulus, inverts every TOGGLE_DIV enabled cycles, 0 when not enabled
module bist_toggle_gen #(
  parameter int unsigned TOGGLE_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic toggle
);

  localparam int unsigned DW = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == DW'(TOGGLE_DIV - 1));

  // en/clr are next-state qualifiers, so the flop lands on the value that
  // belongs to the cycle being entered; the first RUN cycle already shows
  // the inversion owed to cycle_cnt==TOGGLE_DIV-1 when TOGGLE_DIV is 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      toggle  <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      toggle  <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        div_cnt <= '0;
        toggle  <= ~toggle;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end else begin
      toggle <= 1'b0;
    end
  end

endmodule

// File: rtl/bist_sequencer.sv
// BIST sequencer: runs N_ROUNDS rounds of NCLOCK running cycles per start,
// with abort, round/cycle status and a held completion flag.
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   start     : run request, honoured in IDLE and DONE (level sensitive)
//   abort     : synchronous abort, honoured in INIT and RUN
//   init      : one-cycle pulse at the start of every round
//   running   : high for the NCLOCK cycles of each round
//   toggle    : divided stimulus, low outside RUN
//   finish    : one-cycle pulse at the end of a sequence
//   bist_end  : held high in DONE
//   aborted   : held with bist_end when the sequence ended via abort
//   round_idx : current round, holds last value after completion
//   cycle_cnt : running cycles elapsed in the current round
module bist_sequencer
  import bist_sequencer_pkg::*;
#(
  parameter  int unsigned NCLOCK     = BIST_NCLOCK_DEFAULT,
  parameter  int unsigned N_ROUNDS   = 1,
  parameter  int unsigned TOGGLE_DIV = 1,
  localparam int unsigned CNT_W      = width_of(NCLOCK),
  localparam int unsigned RND_W      = width_of(N_ROUNDS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  output logic             init,
  output logic             running,
  output logic             toggle,
  output logic             finish,
  output logic             bist_end,
  output logic             aborted,
  output logic [RND_W-1:0] round_idx,
  output logic [CNT_W-1:0] cycle_cnt
);

  bist_state_e      state_q, state_d;
  logic [RND_W-1:0] rnd_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ab_q, ab_d;
  logic             last_cycle, last_round;

  assign last_cycle = (cycle_cnt == CNT_W'(NCLOCK - 1));
  assign last_round = (round_idx == RND_W'(N_ROUNDS - 1));

  always_comb begin
    state_d = state_q;
    rnd_d   = round_idx;
    cnt_d   = cycle_cnt;
    ab_d    = ab_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_INIT;
          rnd_d   = '0;
          cnt_d   = '0;
          ab_d    = 1'b0;
        end
      end
      ST_INIT: begin
        if (abort) begin
          state_d = ST_FINISH;
          ab_d    = 1'b1;
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_FINISH;
          ab_d    = 1'b1;
        end else if (last_cycle) begin
          if (last_round) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_INIT;
            rnd_d   = round_idx + RND_W'(1);
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cycle_cnt + CNT_W'(1);
        end
      end
      ST_FINISH: state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a flop that
  // lines up with the state it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ab_q      <= 1'b0;
      round_idx <= '0;
      cycle_cnt <= '0;
      init      <= 1'b0;
      running   <= 1'b0;
      finish    <= 1'b0;
      bist_end  <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ab_q      <= ab_d;
      round_idx <= rnd_d;
      cycle_cnt <= cnt_d;
      init      <= (state_d == ST_INIT);
      running   <= (state_d == ST_RUN);
      finish    <= (state_d == ST_FINISH);
      bist_end  <= (state_d == ST_DONE);
      aborted   <= (state_d == ST_DONE) && ab_d;
    end
  end

  bist_toggle_gen #(
    .TOGGLE_DIV(TOGGLE_DIV)
  ) u_toggle (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state_d == ST_RUN),
    .clr    (state_d == ST_INIT),
    .toggle (toggle)
  );

endmodule
